add_seq_ctrl: RTL and testbench
===============================

# add_seq_ctrl

Multi-cycle sequencer that performs wide (8·NBYTES-bit) additions by time-sharing a single instance of the team's 8-bit ripple adder `eight`, one byte per clock, least-significant byte first, with the carry registered between bytes. It sits between an operand producer and a result consumer, each attached through a valid/ready handshake. It replaces a full-width adder where area matters more than latency.

## Interface
- NBYTES, 4, operand width in bytes (≥1); data width W = 8·NBYTES
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  W  operand A, sampled on accept
- b  in  W  operand B, sampled on accept
- cin  in  1  carry-in, sampled on accept
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- sum  out  W  registered result
- cout  out  1  carry out of MSB byte
- ovf  out  1  two's-complement overflow
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch a, b, cin into op_a, op_b, carry_r; idx<=0; go to RUN.
- RUN: the adder is fed op_a[idx], op_b[idx], and carry_r. At the edge: sum byte idx<=adder sum; carry_r<=adder ca; idx<=idx+1. If idx==NBYTES-1, go to DONE.
- DONE: out_valid=1. sum, cout (=carry_r), and ovf stay stable. On out_ready, go to IDLE and clear out_valid.
- ovf = (op_a[W-1]==op_b[W-1]) && (sum[W-1]!=op_a[W-1]). It is computed combinationally and is valid only while out_valid=1.
- idx width is clog2(NBYTES), minimum 1. It never wraps past NBYTES-1.
- in_valid outside IDLE is ignored. Operands are not re-sampled, and no request is queued.
- out_ready outside DONE is ignored.
- sum retains the last result after returning to IDLE. sum is cleared only by reset.
- Reset (any state): state=IDLE, sum=0, carry_r=0, idx=0, out_valid=0, busy=0, in_ready=1. Any in-flight operation is discarded, and no partial result is ever flagged valid.

## Timing
- Accept at edge E0. Bytes are processed at edges E1..E_NBYTES. out_valid rises after edge E_NBYTES, which is NBYTES cycles after accept.
- With out_ready held high, DONE lasts one cycle. The block is back in IDLE after E_NBYTES+1, and the next accept can happen at E_NBYTES+2. Peak throughput is one operation per NBYTES+2 cycles.
- in_ready, out_valid, and busy are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- Adder path: a mux (byte select) into the 8-bit ripple adder into a register. This is the single critical path.
- Async reset takes effect immediately. Reset deassertion is assumed synchronous to clk at the system level.

## Structure
- A shared package `add_seq_pkg` holds:
  - the state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the BYTE=8 constant.
- One sub-module, the existing `eight` (A, B, cin, sum, ca), instantiated once.
- Byte selection is done with indexed part-selects; no additional sub-modules are used.

## Test plan
- Reset: assert rst_n=0 mid-clock → outputs immediately show out_valid=0, busy=0, in_ready=1, sum=0, cout=0.
- NBYTES=4: a=0x000000FF, b=0x00000001, cin=0 → out_valid exactly 4 cycles after accept; sum=0x00000100, cout=0, ovf=0.
- Full carry ripple: a=0xFFFFFFFF, b=0, cin=1 → sum=0x00000000, cout=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, cout=0, ovf=1. Also a=0x80000000, b=0x80000000 → sum=0, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles and pulse in_valid with new operands during RUN and DONE → sum is stable, in_ready=0, and the new operands are ignored. Release out_ready → back in IDLE next cycle; an accept after that returns the new result.
- Reset mid-RUN: apply rst_n=0 two cycles after accept → back in IDLE, out_valid never asserts. The next operation (a=200, b=100, cin=0 in an NBYTES=1 build → sum=44, cout=1) completes in 1 cycle after accept.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared constants for the byte-serial adder sequencer.
package add_seq_pkg;

    localparam int BYTE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/eight.sv
// 8-bit ripple-carry adder, the shared datapath slice of add_seq_ctrl.
module eight (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       ca
);

    logic [8:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            sum[i]   = A[i] ^ B[i] ^ c[i];
            c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        ca = c[8];
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// Wide adder built by time-sharing one 8-bit ripple adder, LSB byte first,
// with valid/ready handshakes on both sides.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  busy
);

    localparam int W  = BYTE * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic [BYTE-1:0] add_a, add_b, add_s;
    logic            add_c;

    // Byte-select mux feeding the shared adder; this is the critical path.
    assign add_a = op_a_q[idx_q*BYTE +: BYTE];
    assign add_b = op_b_q[idx_q*BYTE +: BYTE];

    eight u_add (
        .A   (add_a),
        .B   (add_b),
        .cin (carry_q),
        .sum (add_s),
        .ca  (add_c)
    );

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*BYTE +: BYTE] = add_s;
                carry_d = add_c;
                if (idx_q == LAST) state_d = DONE;
                else               idx_d   = idx_q + 1'b1;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = carry_q;
    assign ovf       = (op_a_q[W-1] == op_b_q[W-1]) && (sum_q[W-1] != op_a_q[W-1]);

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Randomized + directed bench for add_seq_ctrl against a transaction-level model.
module tb_add_seq_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, cout, ovf, busy;
    logic [W-1:0] sum;

    logic         u1_in_valid = 1'b0, u1_out_ready = 1'b0, u1_cin = 1'b0;
    logic [7:0]   u1_a = '0, u1_b = '0;
    logic         u1_in_ready, u1_out_valid, u1_cout, u1_ovf, u1_busy;
    logic [7:0]   u1_sum;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    add_seq_ctrl #(.NBYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    add_seq_ctrl #(.NBYTES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
        .a(u1_a), .b(u1_b), .cin(u1_cin), .out_valid(u1_out_valid), .out_ready(u1_out_ready),
        .sum(u1_sum), .cout(u1_cout), .ovf(u1_ovf), .busy(u1_busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result {ovf, cout, sum} from plain arithmetic.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c);
        logic [W:0] r;
        logic       o;
        r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        return {o, r};
    endfunction

    // Model: -1 = idle, k>0 = k edges until the result shows, 0 = result held.
    int           m_left = -1;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= -1;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_left == -1) begin
            if (in_valid) begin
                {m_ovf, m_cout, m_sum} <= ref_add(a, b, cin);
                m_left <= NB;
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
        end else if (out_ready) begin
            m_left <= -1;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_left == -1);
        chk("out_valid", out_valid, m_left == 0);
        chk("busy", busy, m_left != -1);
        if (m_left <= 0) begin
            chk("sum", sum, m_sum);
            chk("cout", cout, m_cout);
        end
        if (m_left == 0) chk("ovf", ovf, m_ovf);
    end

    task automatic start4(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        int g = 0;
        while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run4(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic [W-1:0] es, input logic ec, input logic eo);
        int cyc = 0;
        start4(ta, tb, tc);
        while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        chk("latency", cyc, NB);
        chk("d_sum", sum, es);
        chk("d_cout", cout, ec);
        chk("d_ovf", ovf, eo);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("d_idle", in_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_sum", sum, '0);
        chk("rst_cout", cout, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run4(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        run4(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        run4(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run4(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

        // Backpressure with competing requests during RUN and DONE.
        start4(32'h1234_5678, 32'h1111_1111, 1'b0);
        for (int i = 0; i < NB + 5; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom);
            chk("bp_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_sum", sum, 32'h2345_6789);
        chk("bp_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_idle", in_ready, 1'b1);
        run4(32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0004, 1'b0, 1'b0);

        // Reset two cycles into RUN.
        start4(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", out_valid, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_in_ready", in_ready, 1'b1);
        chk("mr_sum", sum, '0);
        chk("mr_cout", cout, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < NB + 2; i++) begin
            @(posedge clk); #1;
            chk("mr_no_valid", out_valid, 1'b0);
        end

        // Single-byte build: one cycle from accept to result.
        u1_a = 8'd200; u1_b = 8'd100; u1_cin = 1'b0; u1_in_valid = 1'b1;
        @(posedge clk); #1;
        u1_in_valid = 1'b0;
        chk("u1_lat0", u1_out_valid, 1'b0);
        @(posedge clk); #1;
        chk("u1_valid", u1_out_valid, 1'b1);
        chk("u1_sum", u1_sum, 8'd44);
        chk("u1_cout", u1_cout, 1'b1);
        chk("u1_ovf", u1_ovf, 1'b0);
        u1_out_ready = 1'b1;
        @(posedge clk); #1;
        u1_out_ready = 1'b0;
        chk("u1_idle", u1_in_ready, 1'b1);
        u1_a = 8'h7F; u1_b = 8'h01; u1_in_valid = 1'b1;
        @(posedge clk); #1;
        u1_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("u1_sum2", u1_sum, 8'h80);
        chk("u1_ovf2", u1_ovf, 1'b1);
        chk("u1_cout2", u1_cout, 1'b0);

        run4(32'd200, 32'd100, 1'b0, 32'd300, 1'b0, 1'b0);

        // Random traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            cin       = 1'($urandom);
            case ($urandom_range(0, 5))
                0: a = 32'hFFFF_FFFF;
                1: a = 32'h8000_0000;
                2: a = 32'h7FFF_FFFF;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 4) == 0) ? ~a : $urandom;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (NB + 4) @(posedge clk);
        #1;
        chk("drain_idle", in_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
